// File: rtl/live_led_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : live_led_monitor
//  Description : Receive-side heartbeat checker. Synchronises an incoming
//                heartbeat square wave, measures every half-period and reports
//                alive/dead status, the last measured half-period and a
//                saturating count of entries into the DEAD state.
//  Ports       : clk          system clock
//                reset        synchronous, active-low reset
//                hb_in        heartbeat input, asynchronous to clk
//                alive        1 while the link is in ALIVE (registered)
//                dead         1 while the link is in DEAD (registered)
//                half_period  cycles between the last two detected edges
//                err_cnt      number of entries into DEAD, saturates at 255
//  Revision    : 1.0 - initial release
// ============================================================================
module live_led_monitor #(
  parameter int CNT_W      = 26,
  parameter int MIN_HALF   = 45000000,
  parameter int MAX_HALF   = 55000000,
  parameter int LOCK_EDGES = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hb_in,
  output logic             alive,
  output logic             dead,
  output logic [CNT_W-1:0] half_period,
  output logic [7:0]       err_cnt
);

  localparam int                GOOD_W = $clog2(LOCK_EDGES + 1);
  localparam logic [CNT_W-1:0]  C_MIN  = CNT_W'(MIN_HALF);
  localparam logic [CNT_W-1:0]  C_MAX  = CNT_W'(MAX_HALF);
  localparam logic [GOOD_W-1:0] C_LOCK = GOOD_W'(LOCK_EDGES);

  typedef enum logic [1:0] {
    ST_ACQ   = 2'd0,
    ST_LOCK  = 2'd1,
    ST_ALIVE = 2'd2,
    ST_DEAD  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_sync1;
  logic              r_sync2;
  logic              r_prev;
  logic [CNT_W-1:0]  r_cnt;
  logic [GOOD_W-1:0] r_good;
  logic [GOOD_W-1:0] w_good_next;
  logic [GOOD_W-1:0] w_good_inc;
  logic [CNT_W-1:0]  w_h;
  logic              w_edge;
  logic              w_timeout;
  logic              w_in_range;

  // Both polarities of the heartbeat count as an edge.
  assign w_edge     = r_sync2 ^ r_prev;
  // Measured half-period includes the edge cycle itself.
  assign w_h        = r_cnt + CNT_W'(1);
  // r_cnt saturates at MAX_HALF, so reaching it without an edge means
  // MAX_HALF+1 cycles have elapsed since the last edge.
  assign w_timeout  = !w_edge && (r_cnt == C_MAX);
  assign w_in_range = (w_h >= C_MIN) && (w_h <= C_MAX);
  assign w_good_inc = r_good + GOOD_W'(1);

  always_comb begin
    w_next      = r_state;
    w_good_next = r_good;
    case (r_state)
      ST_ACQ: begin
        if (w_edge) begin
          // This edge only sets the timing origin.
          w_next      = ST_LOCK;
          w_good_next = '0;
        end else if (w_timeout) begin
          w_next = ST_DEAD;
        end
      end
      ST_LOCK: begin
        if (w_edge) begin
          if (w_in_range) begin
            w_good_next = w_good_inc;
            if (w_good_inc == C_LOCK) begin
              w_next = ST_ALIVE;
            end
          end else begin
            // An off-frequency half-period restarts the lock count
            // without being treated as a fault.
            w_good_next = '0;
          end
        end else if (w_timeout) begin
          w_next = ST_DEAD;
        end
      end
      ST_ALIVE: begin
        // Only a too-short half-period (glitch) or a timeout drops the link.
        if (w_edge) begin
          if (w_h < C_MIN) begin
            w_next = ST_DEAD;
          end
        end else if (w_timeout) begin
          w_next = ST_DEAD;
        end
      end
      ST_DEAD: begin
        if (w_edge) begin
          w_next      = ST_LOCK;
          w_good_next = '0;
        end
      end
      default: begin
        w_next      = ST_ACQ;
        w_good_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_prev      <= 1'b0;
      r_cnt       <= '0;
      r_good      <= '0;
      r_state     <= ST_ACQ;
      alive       <= 1'b0;
      dead        <= 1'b0;
      half_period <= '0;
      err_cnt     <= 8'd0;
    end else begin
      r_sync1 <= hb_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;

      if (w_edge) begin
        r_cnt       <= '0;
        half_period <= w_h;
      end else if (r_cnt != C_MAX) begin
        r_cnt <= w_h;
      end

      r_state <= w_next;
      r_good  <= w_good_next;

      // Status flags follow the registered state one cycle later.
      alive <= (r_state == ST_ALIVE);
      dead  <= (r_state == ST_DEAD);

      if ((w_next == ST_DEAD) && (r_state != ST_DEAD) && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_live_led_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_live_led_monitor
//  Description : Self-checking bench for live_led_monitor. Stimulus toggles
//                the heartbeat with directed level lengths and queues the
//                expected outputs with the cycle they are due; a monitor
//                compares the queue head against the DUT on each falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_live_led_monitor;

  localparam int F_ALIVE = 0;
  localparam int F_DEAD  = 1;
  localparam int F_HP    = 2;
  localparam int F_EC    = 3;

  typedef struct {
    int cyc;
    int field;
    int val;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       hb_in;
  logic       alive;
  logic       dead;
  logic [7:0] half_period;
  logic [7:0] err_cnt;

  int   cyc;
  int   n_vec;
  int   n_err;
  exp_t q[$];
  exp_t m_e;
  int   m_act;

  live_led_monitor #(
    .CNT_W      (8),
    .MIN_HALF   (8),
    .MAX_HALF   (12),
    .LOCK_EDGES (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .hb_in       (hb_in),
    .alive       (alive),
    .dead        (dead),
    .half_period (half_period),
    .err_cnt     (err_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string fname(input int f);
    case (f)
      F_ALIVE: return "alive";
      F_DEAD:  return "dead";
      F_HP:    return "half_period";
      default: return "err_cnt";
    endcase
  endfunction

  // Queue an expectation; a negative value means "don't check".
  task automatic push(input int c, input int f, input int v);
    exp_t e;
    if (v >= 0) begin
      e.cyc   = c;
      e.field = f;
      e.val   = v;
      q.push_back(e);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Toggle hb_in now and hold it for n cycles. The edge is processed 3 cycles
  // after the toggle (half_period/err_cnt/state update), alive/dead one later.
  // hp is the half-period measured by this toggle, i.e. the previous level.
  task automatic lvl(input int n, input int hp, input int al, input int dd, input int ec);
    int p;
    p     = cyc;
    hb_in = ~hb_in;
    push(p + 3, F_HP, hp);
    push(p + 3, F_EC, ec);
    push(p + 4, F_ALIVE, al);
    push(p + 4, F_DEAD, dd);
    step(n);
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      m_e = q.pop_front();
      case (m_e.field)
        F_ALIVE: m_act = int'(alive);
        F_DEAD:  m_act = int'(dead);
        F_HP:    m_act = int'(half_period);
        default: m_act = int'(err_cnt);
      endcase
      n_vec++;
      if (m_e.cyc != cyc || m_act !== m_e.val) begin
        n_err++;
        $display("FAIL %s at cyc %0d (due %0d): got %0d, want %0d",
                 fname(m_e.field), cyc, m_e.cyc, m_act, m_e.val);
      end
    end
  end

  initial begin
    int c;
    int p;
    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    hb_in = 1'b0;

    // 1. Reset with hb_in toggling, then hold low until timeout.
    for (int k = 1; k <= 2; k++) begin
      push(k, F_ALIVE, 0);
      push(k, F_DEAD, 0);
      push(k, F_HP, 0);
      push(k, F_EC, 0);
    end
    push(14, F_DEAD, 0);
    push(14, F_EC, 0);
    push(15, F_DEAD, 0);
    push(15, F_EC, 1);
    push(16, F_DEAD, 1);
    push(16, F_ALIVE, 0);
    step(1);
    hb_in = 1'b1;
    step(1);
    hb_in = 1'b0;
    reset = 1'b1;
    step(18);

    // 2. 10-cycle levels from DEAD: origin edge sees the saturated count (13).
    lvl(10, 13, 0, 0, 1);
    lvl(10, 10, 0, 0, 1);
    lvl(10, 10, 0, 0, 1);
    lvl(10, 10, 1, 0, 1);

    // 3. Stop toggling while ALIVE: DEAD decided 13 cycles after the edge.
    p = cyc - 10;
    push(p + 16, F_ALIVE, 1);
    push(p + 16, F_DEAD, 0);
    push(p + 16, F_EC, 2);
    push(p + 17, F_ALIVE, 0);
    push(p + 17, F_DEAD, 1);
    step(10);

    // 4. Relock, then a 6-cycle glitch level while ALIVE, then recover.
    lvl(10, 13, 0, 0, 2);
    lvl(10, 10, 0, 0, 2);
    lvl(10, 10, 0, 0, 2);
    lvl(10, 10, 1, 0, 2);
    lvl(6, 10, 1, 0, 2);
    lvl(10, 6, 0, 1, 3);
    lvl(10, 10, 0, 0, 3);
    lvl(10, 10, 0, 0, 3);
    lvl(10, 10, 0, 0, 3);
    lvl(10, 10, 1, 0, 3);

    // 5. Glitch to DEAD, relock with 10,7,10,10,10.
    lvl(5, 10, 1, 0, 3);
    lvl(10, 5, 0, 1, 4);
    lvl(10, 10, 0, 0, 4);
    lvl(7, 10, 0, 0, 4);
    lvl(10, 7, 0, 0, 4);
    lvl(10, 10, 0, 0, 4);
    lvl(10, 10, 0, 0, 4);
    lvl(8, 10, 1, 0, 4);
    // Boundary half-periods 8 and 12 keep ALIVE.
    lvl(12, 8, 1, 0, 4);
    lvl(5, 12, 1, 0, 4);
    lvl(10, 5, 0, 1, 5);
    // Boundaries 8/12 count as good in LOCK; 13 (edge on timeout cycle) clears.
    lvl(8, 10, 0, 0, 5);
    lvl(12, 8, 0, 0, 5);
    lvl(13, 12, 0, 0, 5);
    lvl(8, 13, 0, 0, 5);
    lvl(12, 8, 0, 0, 5);
    lvl(10, 12, 0, 0, 5);
    lvl(10, 10, 1, 0, 5);
    p = cyc - 10;
    push(p + 16, F_EC, 6);
    push(p + 17, F_ALIVE, 0);
    push(p + 17, F_DEAD, 1);
    step(6);

    // 6. 256 recover/timeout cycles: err_cnt saturates at 255.
    for (int i = 0; i < 256; i++) begin
      lvl(16, 13, -1, -1, (6 + i > 255) ? 255 : 6 + i);
    end
    lvl(10, 13, 0, 0, 255);
    lvl(10, 10, 0, 0, 255);
    lvl(10, 10, 0, 0, 255);
    lvl(5, 10, 1, 0, 255);

    // One-cycle reset mid-ALIVE; afterwards behaves as fresh ACQ.
    c = cyc;
    push(c + 1, F_ALIVE, 0);
    push(c + 1, F_DEAD, 0);
    push(c + 1, F_HP, 0);
    push(c + 1, F_EC, 0);
    push(c + 14, F_DEAD, 0);
    push(c + 14, F_EC, 1);
    push(c + 15, F_DEAD, 1);
    push(c + 15, F_ALIVE, 0);
    reset = 1'b0;
    hb_in = 1'b0;
    step(1);
    reset = 1'b1;
    step(20);

    if (q.size() != 0) begin
      n_err += q.size();
      $display("FAIL unchecked_expectations: got %0d left, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
